// File: rtl/ro_entropy_pkg.sv
// Shared types and constants for the ring-oscillator entropy controller.
package ro_entropy_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    WARMUP  = 3'd2,
    COLLECT = 3'd3,
    DELIVER = 3'd4
  } state_t;

  localparam int WORD_WIDTH = 32;
  localparam int REP_LIMIT  = 32;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ro_sync2.sv
// Two-flop synchroniser for the free-running oscillator outputs.
module ro_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ro_entropy_ctrl.sv
// Seeds, warms up and samples a ring-oscillator bank, delivering 32-bit words.
// Define RO_ENTROPY_HEALTH_EN to add the repetition-count health test.
module ro_entropy_ctrl
  import ro_entropy_pkg::*;
#(
  parameter int NUM_LOOPS     = 4,
  parameter int SEED_CYCLES   = 16,
  parameter int WARMUP_CYCLES = 1024,
  parameter int SAMPLE_DIV    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  reseed,
  output logic                  loop_ctrl,
  output logic [NUM_LOOPS-1:0]  loop_seed,
  input  logic [NUM_LOOPS-1:0]  loop_d,
  output logic [WORD_WIDTH-1:0] entropy_data,
  output logic                  entropy_valid,
  input  logic                  entropy_ready,
  output logic                  busy,
  output logic                  health_fail
);

  localparam int CNT_W = $clog2(max3(SEED_CYCLES, WARMUP_CYCLES, SAMPLE_DIV) + 1);
  localparam int BIT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] SEED_LAST = CNT_W'(SEED_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_WIDTH - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_count_q, bit_count_d;
  // Only the first 31 samples are stored; the 32nd goes straight into the output word.
  logic [WORD_WIDTH-2:0]   word_q, word_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic [NUM_LOOPS-1:0]    loop_seed_q, loop_seed_d;
  logic                    seed_phase_q, seed_phase_d;
  logic                    pending_q, pending_d;
  logic                    go_idle, enter_seed, health_trip;

  logic [NUM_LOOPS-1:0]    loop_sync;
  logic [NUM_LOOPS-1:0]    seed_pattern;
  logic                    sample_bit;

  ro_sync2 #(.WIDTH(NUM_LOOPS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (loop_d),
    .q     (loop_sync)
  );

  assign sample_bit = ^loop_sync;

  for (genvar gi = 0; gi < NUM_LOOPS; gi++) begin : g_seed
    assign seed_pattern[gi] = ((gi % 2) == 1);
  end

`ifdef RO_ENTROPY_HEALTH_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_next;
  logic             last_bit_q, last_bit_d;
  logic             health_q, health_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q  <= '0;
      last_bit_q <= 1'b0;
      health_q   <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      last_bit_q <= last_bit_d;
      health_q   <= health_d;
    end
  end

  assign health_fail = health_q;
`else
  assign health_fail = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_count_d  = bit_count_q;
    word_d       = word_q;
    data_d       = data_q;
    valid_d      = valid_q;
    loop_seed_d  = loop_seed_q;
    seed_phase_d = seed_phase_q;
    pending_d    = pending_q;
    go_idle      = 1'b0;
    enter_seed   = 1'b0;
    health_trip  = 1'b0;
`ifdef RO_ENTROPY_HEALTH_EN
    rep_cnt_d    = rep_cnt_q;
    last_bit_d   = last_bit_q;
    health_d     = health_q;
    rep_next     = '0;
`endif
    case (state_q)
      IDLE: if (enable) enter_seed = 1'b1;
      SEED: begin
        if (!enable)                go_idle = 1'b1;
        else if (reseed)            enter_seed = 1'b1;
        else if (cnt_q == SEED_LAST) begin
          state_d = WARMUP;
          cnt_d   = '0;
        end else                    cnt_d = cnt_q + 1'b1;
      end
      WARMUP: begin
        if (!enable)                go_idle = 1'b1;
        else if (reseed)            enter_seed = 1'b1;
        else if (cnt_q == WARM_LAST) begin
          state_d     = COLLECT;
          cnt_d       = '0;
          bit_count_d = '0;
          word_d      = '0;
        end else                    cnt_d = cnt_q + 1'b1;
      end
      COLLECT: begin
        if (!enable)                go_idle = 1'b1;
        else if (reseed)            enter_seed = 1'b1;
        else if (cnt_q != DIV_LAST) cnt_d = cnt_q + 1'b1;
        else begin
          cnt_d = '0;
`ifdef RO_ENTROPY_HEALTH_EN
          rep_next    = (rep_cnt_q != '0 && sample_bit == last_bit_q) ?
                        rep_cnt_q + 1'b1 : REP_W'(1);
          rep_cnt_d   = rep_next;
          last_bit_d  = sample_bit;
          health_trip = (rep_next == REP_MAX);
          if (health_trip) health_d = 1'b1;
`endif
          if (health_trip) enter_seed = 1'b1;
          else if (bit_count_q == BIT_LAST) begin
            data_d      = {word_q, sample_bit};
            valid_d     = 1'b1;
            bit_count_d = '0;
            word_d      = '0;
            state_d     = DELIVER;
          end else begin
            word_d      = {word_q[WORD_WIDTH-3:0], sample_bit};
            bit_count_d = bit_count_q + 1'b1;
          end
        end
      end
      DELIVER: begin
        if (reseed) pending_d = 1'b1;
        // Enable low still lets the current word drain before going idle.
        if (valid_q && entropy_ready) begin
          valid_d     = 1'b0;
          cnt_d       = '0;
          bit_count_d = '0;
          if (!enable)                    go_idle = 1'b1;
          else if (pending_q || reseed)   enter_seed = 1'b1;
          else                            state_d = COLLECT;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d     = IDLE;
      cnt_d       = '0;
      bit_count_d = '0;
      word_d      = '0;
      pending_d   = 1'b0;
    end

    if (enter_seed) begin
      state_d      = SEED;
      cnt_d        = '0;
      bit_count_d  = '0;
      word_d       = '0;
      pending_d    = 1'b0;
      loop_seed_d  = seed_pattern ^ {NUM_LOOPS{seed_phase_q}};
      seed_phase_d = ~seed_phase_q;
`ifdef RO_ENTROPY_HEALTH_EN
      rep_cnt_d = '0;
      // A deliberate reseed clears the flag; a health-triggered one keeps it.
      if (!health_trip && state_q != IDLE) health_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_count_q  <= '0;
      word_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      loop_seed_q  <= '0;
      seed_phase_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_count_q  <= bit_count_d;
      word_q       <= word_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      loop_seed_q  <= loop_seed_d;
      seed_phase_q <= seed_phase_d;
      pending_q    <= pending_d;
    end
  end

  assign loop_ctrl     = (state_q == IDLE) || (state_q == SEED);
  assign loop_seed     = loop_seed_q;
  assign entropy_data  = data_q;
  assign entropy_valid = valid_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/ro_entropy_ctrl.md
Name: ro_entropy_ctrl

Overview:
Controller for a bank of seedable inverter-loop ring oscillators, each exposing a ctrl/seed input pair and a free-running output d. It seeds the loops, releases them, and waits out a warm-up period. It then samples the XOR of the synchronised loop outputs at a programmable rate, packs the bits into 32-bit words and hands each word downstream over a valid/ready handshake. It sits between the oscillator bank and the entropy consumer (mixer or conditioning core).

Parameters:
NUM_LOOPS, 4, number of oscillator loops driven and sampled (1..16)
SEED_CYCLES, 16, clock cycles loop_ctrl is held high during seeding (>=1)
WARMUP_CYCLES, 1024, free-run cycles after seeding before any sample counts (>=1)
SAMPLE_DIV, 8, clock cycles between samples (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  level; high = generate entropy
reseed  input  1  single-cycle pulse requesting a reseed
loop_ctrl  output  1  common ctrl to all loops; 1 = force seed, 0 = free-run
loop_seed  output  NUM_LOOPS  per-loop seed value
loop_d  input  NUM_LOOPS  raw asynchronous loop outputs
entropy_data  output  32  collected word
entropy_valid  output  1  entropy_data is valid
entropy_ready  input  1  consumer accepts the word
busy  output  1  high in any state other than IDLE
health_fail  output  1  sticky health-test failure (see Optional Feature)

Behaviour:
- Reset values:
  - state = IDLE; loop_ctrl = 1; loop_seed = 0.
  - entropy_data = 0; entropy_valid = 0; busy = 0; health_fail = 0.
  - All counters = 0; seed_phase = 0.
- loop_d synchronisation:
  - Each bit passes through a 2-flop synchroniser.
  - The sample bit is the XOR of all synchronised bits.
  - Total latency from loop_d to the sample register is 2 cycles.
- States: IDLE, SEED, WARMUP, COLLECT, DELIVER.
- IDLE:
  - loop_ctrl = 1.
  - When enable = 1, go to SEED.
- SEED:
  - loop_ctrl = 1; loop_seed[i] = i[0] XOR seed_phase.
  - Stay exactly SEED_CYCLES cycles, then go to WARMUP.
  - seed_phase toggles on each entry to SEED.
- WARMUP:
  - loop_ctrl = 0.
  - Stay WARMUP_CYCLES cycles, then go to COLLECT with the divider and bit count cleared.
- COLLECT:
  - The divider counts 0..SAMPLE_DIV-1. On the cycle it equals SAMPLE_DIV-1: word <= {word[30:0], sample_bit} and bit_count increments.
  - After the 32nd sample: entropy_data <= word, entropy_valid <= 1, go to DELIVER.
- DELIVER:
  - The loops keep running, but sampling pauses.
  - entropy_data and entropy_valid stay stable until entropy_valid && entropy_ready. Valid is never retracted.
  - On handshake: entropy_valid = 0 on the next cycle and bit_count = 0.
  - After handshake: pending reseed -> SEED; else enable = 1 -> COLLECT; else IDLE.
- enable deasserted:
  - In SEED, WARMUP or COLLECT: go to IDLE next cycle, discard the partial word, loop_ctrl = 1.
  - In DELIVER: complete the handshake first, then go to IDLE.
- reseed:
  - In SEED, WARMUP or COLLECT: go to SEED next cycle and discard the partial word.
  - In DELIVER: latched as pending.
  - In IDLE: ignored.
  - reseed coinciding with enable falling: enable wins (go to IDLE).
- Back-to-back: with entropy_ready held at 1, consecutive words are spaced 32*SAMPLE_DIV + 1 cycles.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronous reset).

Optional Feature:
Macro RO_ENTROPY_HEALTH_EN.
- Defined:
  - A repetition-count test runs on sample_bit.
  - 32 consecutive identical samples sets health_fail, which is sticky until reset or the next reseed.
  - The current word is discarded (no DELIVER) and the controller enters SEED automatically.
- Not defined:
  - health_fail is tied to 0 and no test logic is present.

Decomposition:
- Package ro_entropy_pkg holds:
  - the state typedef and encodings (IDLE=0, SEED=1, WARMUP=2, COLLECT=3, DELIVER=4);
  - WORD_WIDTH = 32;
  - REP_LIMIT = 32.
- Sub-module ro_sync2: a parameterised-width 2-flop synchroniser for loop_d, reset to 0.

Test Plan:
- Reset then enable=1 with a model loop bank (NUM_LOOPS=4) -> loop_ctrl high exactly 16 cycles, loop_seed=4'b1010 then 4'b0101 on the next seeding, loop_ctrl low after.
- Model loop_d toggling with a known pattern, SAMPLE_DIV=8, ready=1 -> first valid 16+1024+32*8 (+sync/register offset) cycles after enable; data matches the reference XOR-shift model.
- Hold entropy_ready=0 for 500 cycles in DELIVER -> entropy_valid and entropy_data constant; pulse ready -> valid low next cycle.
- reseed pulse mid-COLLECT (after 10 samples) -> SEED next cycle, partial word discarded; reseed during DELIVER -> SEED only after handshake.
- enable dropped mid-WARMUP -> IDLE next cycle, loop_ctrl=1, busy=0; reset asserted mid-COLLECT -> all outputs at reset values without a clock edge.
- With RO_ENTROPY_HEALTH_EN: loop_d stuck at 0 -> health_fail=1 after 32 samples, no valid, automatic reseed.
